round_timer_ctrl: RTL and testbench

//  Sequences the per-round countdown datapath for Frogger: divides frame_clk edges into seconds,

---
 rtl/round_timer_ctrl_pkg.sv | 22 ++
 rtl/round_timer_ctrl_if.sv | 25 ++
 rtl/round_timer_ctrl_bcd_counter.sv | 73 +++++++
 rtl/round_timer_ctrl.sv | 154 +++++++++++++++
 tb/tb_round_timer_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/round_timer_ctrl_pkg.sv
// Shared types and helpers for the Frogger round timer.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD,
        EXPIRED
    } timer_state_t;

    localparam int MAX_SECONDS = 99;

    // Convert a 0..99 value to packed {tens, ones} BCD; out-of-range inputs clamp.
    function automatic logic [7:0] to_bcd2(input int value);
        int v;
        v = value;
        if (v < 0) v = 0;
        if (v > MAX_SECONDS) v = MAX_SECONDS;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/round_timer_ctrl_if.sv
// Game-FSM <-> round timer signal bundle; master = game side, slave = timer.
interface round_timer_ctrl_if;

    logic       frame_clk;
    logic       start;
    logic       hold;
    logic       add_bonus;
    logic [3:0] tens_digit;
    logic [3:0] ones_digit;
    logic       running;
    logic       expired;
    logic       timeout;
    logic       warn;

    modport master (
        output frame_clk, start, hold, add_bonus,
        input  tens_digit, ones_digit, running, expired, timeout, warn
    );

    modport slave (
        input  frame_clk, start, hold, add_bonus,
        output tens_digit, ones_digit, running, expired, timeout, warn
    );

endinterface

// File: rtl/round_timer_ctrl_bcd_counter.sv
// Two-digit BCD seconds register: load, decrement (stops at 00) and, when
// BONUS_TIME_EN is defined, a saturating bonus add that folds in a same-cycle decrement.
module timer_bcd_counter
    import game_pkg::*;
#(
    parameter int START_SECONDS = 60,
    parameter int BONUS_SECONDS = 5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       load_i,
    input  logic       dec_i,
`ifdef BONUS_TIME_EN
    input  logic       add_i,
`endif
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       zero_o
);

    localparam logic [7:0] START_BCD = to_bcd2(START_SECONDS);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;

    assign zero_o = (tens_q == 4'd0) && (ones_q == 4'd0);
    assign tens_o = tens_q;
    assign ones_o = ones_q;

`ifdef BONUS_TIME_EN
    int unsigned sum_bin;

    // Bonus result in binary: count + bonus, minus a coincident tick, capped at 99.
    always_comb begin
        sum_bin = 32'(tens_q) * 32'd10 + 32'(ones_q) + 32'(BONUS_SECONDS);
        if (dec_i && !zero_o) sum_bin = sum_bin - 32'd1;
        if (sum_bin > 32'(MAX_SECONDS)) sum_bin = 32'(MAX_SECONDS);
    end
`else
    localparam int unused_bonus_seconds = BONUS_SECONDS;
`endif

    // Next digits: load beats bonus beats plain decrement.
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (load_i) begin
            {tens_d, ones_d} = START_BCD;
`ifdef BONUS_TIME_EN
        end else if (add_i) begin
            {tens_d, ones_d} = to_bcd2(int'(sum_bin));
`endif
        end else if (dec_i && !zero_o) begin
            if (ones_q == 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
    end

    // Digit register; reset restores the round start value.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            {tens_q, ones_q} <= START_BCD;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/round_timer_ctrl.sv
// Frogger round countdown: frame_clk synchroniser, frames-per-second divider and
// IDLE/RUN/HOLD/EXPIRED FSM around a BCD seconds counter.
// Optional feature: define BONUS_TIME_EN to enable add_bonus.
module round_timer_ctrl
    import game_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 60,
    parameter int START_SECONDS  = 60,
    parameter int WARN_SECONDS   = 10,
    parameter int BONUS_SECONDS  = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    round_timer_ctrl_if.slave tif
);

    localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_SEC - 1);

    logic         sync1_q, sync2_q, sync3_q;
    logic         frame_edge;
    timer_state_t state_q, state_d;
    logic [7:0]   frame_cnt_q, frame_cnt_d;
    logic         sec_tick;
    logic         load_req, dec_req, add_req, bonus_req;
    logic         running_q, expired_q, timeout_q;
    logic [3:0]   tens, ones;
    logic         zero;
    logic         count_is_one;
    int unsigned  count_bin;

    assign frame_edge   = sync2_q & ~sync3_q;
    assign count_is_one = (tens == 4'd0) && (ones == 4'd1);
    assign count_bin    = 32'(tens) * 32'd10 + 32'(ones);

`ifdef BONUS_TIME_EN
    assign bonus_req = tif.add_bonus & ~tif.start;
`else
    logic unused_bonus;
    assign bonus_req    = 1'b0;
    assign unused_bonus = ^{tif.add_bonus, add_req};
`endif

    // Two-flop synchroniser plus a history flop for rising-edge detection.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= tif.frame_clk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Next state, frame divider and counter controls; start > hold > sec_tick.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        sec_tick    = 1'b0;
        load_req    = 1'b0;
        dec_req     = 1'b0;
        add_req     = 1'b0;
        case (state_q)
            IDLE: begin
                if (tif.start) begin
                    state_d     = RUN;
                    load_req    = 1'b1;
                    frame_cnt_d = '0;
                end
            end
            RUN: begin
                add_req = bonus_req;
                if (tif.start) begin
                    load_req    = 1'b1;
                    frame_cnt_d = '0;
                end else if (tif.hold) begin
                    state_d = HOLD;
                end else if (frame_edge) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d = '0;
                        sec_tick    = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
                if (sec_tick) begin
                    dec_req = 1'b1;
                    // A coincident bonus keeps the round alive instead of expiring.
                    if (count_is_one && !bonus_req) state_d = EXPIRED;
                end
            end
            HOLD: begin
                add_req = bonus_req;
                if (tif.start) begin
                    state_d     = RUN;
                    load_req    = 1'b1;
                    frame_cnt_d = '0;
                end else if (!tif.hold) begin
                    state_d = RUN;
                end
            end
            EXPIRED: begin
                if (tif.start) begin
                    state_d     = RUN;
                    load_req    = 1'b1;
                    frame_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, divider and registered status outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            running_q   <= 1'b0;
            expired_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            running_q   <= (state_d == RUN);
            expired_q   <= (state_d == EXPIRED);
            timeout_q   <= (state_q != EXPIRED) && (state_d == EXPIRED);
        end
    end

    timer_bcd_counter #(
        .START_SECONDS (START_SECONDS),
        .BONUS_SECONDS (BONUS_SECONDS)
    ) u_counter (
        .Clk    (Clk),
        .Reset  (Reset),
        .load_i (load_req),
        .dec_i  (dec_req),
`ifdef BONUS_TIME_EN
        .add_i  (add_req),
`endif
        .tens_o (tens),
        .ones_o (ones),
        .zero_o (zero)
    );

    assign tif.tens_digit = tens;
    assign tif.ones_digit = ones;
    assign tif.running    = running_q;
    assign tif.expired    = expired_q;
    assign tif.timeout    = timeout_q;
    assign tif.warn       = running_q & ~zero & (count_bin <= 32'(WARN_SECONDS));

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl (FRAMES_PER_SEC=2, START=3, WARN=2, BONUS=5).
module tb_round_timer_ctrl;

    logic Clk;
    logic Reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    round_timer_ctrl_if tif();

    round_timer_ctrl #(
        .FRAMES_PER_SEC (2),
        .START_SECONDS  (3),
        .WARN_SECONDS   (2),
        .BONUS_SECONDS  (5)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .tif   (tif)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic pulse_start();
        tif.start = 1'b1;
        tick(1);
        tif.start = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick(2);
        Reset = 1'b0;
    endtask

    // One frame_clk period; optional add_bonus lands in the cycle the edge is consumed.
    task automatic frame_pulse(input logic bonus_at_edge, output int to_cnt);
        to_cnt = 0;
        tif.frame_clk = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) tif.add_bonus = bonus_at_edge;
            @(negedge Clk);
            if (i == 2) begin
                tif.add_bonus = 1'b0;
                tif.frame_clk = 1'b0;
            end
            if (tif.timeout === 1'b1) to_cnt++;
        end
    endtask

    task automatic frames(input int n);
        int t;
        for (int i = 0; i < n; i++) frame_pulse(1'b0, t);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit} !== 8'h03) begin
            n_fail++; $display("FAIL reset_digits: got %h expected 03", {tif.tens_digit, tif.ones_digit});
        end
        n_checks++;
        if ({tif.running, tif.expired, tif.timeout, tif.warn} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {tif.running, tif.expired, tif.timeout, tif.warn});
        end
    endtask

    task automatic test_countdown();
        int t0, t1;
        pulse_start();
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit, tif.running, tif.warn} !== {8'h03, 2'b10}) begin
            n_fail++; $display("FAIL start_run: got %h/%b%b expected 03/10", {tif.tens_digit, tif.ones_digit}, tif.running, tif.warn);
        end
        frames(2);
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit, tif.warn} !== {8'h02, 1'b1}) begin
            n_fail++; $display("FAIL count_02: got %h warn %b expected 02 warn 1", {tif.tens_digit, tif.ones_digit}, tif.warn);
        end
        frames(2);
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit, tif.warn} !== {8'h01, 1'b1}) begin
            n_fail++; $display("FAIL count_01: got %h warn %b expected 01 warn 1", {tif.tens_digit, tif.ones_digit}, tif.warn);
        end
        frame_pulse(1'b0, t0);
        frame_pulse(1'b0, t1);
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit} !== 8'h00) begin
            n_fail++; $display("FAIL count_00: got %h expected 00", {tif.tens_digit, tif.ones_digit});
        end
        n_checks++;
        if (t0 + t1 !== 1) begin
            n_fail++; $display("FAIL timeout_width: got %0d cycles expected 1", t0 + t1);
        end
        n_checks++;
        if ({tif.running, tif.expired, tif.timeout, tif.warn} !== 4'b0100) begin
            n_fail++; $display("FAIL expired_flags: got %b expected 0100", {tif.running, tif.expired, tif.timeout, tif.warn});
        end
        frame_pulse(1'b0, t0);
        frame_pulse(1'b0, t1);
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit, tif.expired} !== {8'h00, 1'b1} || t0 + t1 !== 0) begin
            n_fail++; $display("FAIL expired_stays: got %h exp %b timeouts %0d expected 00 1 0", {tif.tens_digit, tif.ones_digit}, tif.expired, t0 + t1);
        end
    endtask

    task automatic test_hold();
        pulse_start();
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit, tif.running, tif.expired} !== {8'h03, 2'b10}) begin
            n_fail++; $display("FAIL restart_from_expired: got %h/%b%b expected 03/10", {tif.tens_digit, tif.ones_digit}, tif.running, tif.expired);
        end
        frames(1);
        tif.hold = 1'b1;
        tick(1);
        frames(10);
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit, tif.running} !== {8'h03, 1'b0}) begin
            n_fail++; $display("FAIL hold_frozen: got %h run %b expected 03 run 0", {tif.tens_digit, tif.ones_digit}, tif.running);
        end
        tif.hold = 1'b0;
        tick(1);
        frames(1);
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit, tif.running} !== {8'h02, 1'b1}) begin
            n_fail++; $display("FAIL hold_release_dec: got %h run %b expected 02 run 1", {tif.tens_digit, tif.ones_digit}, tif.running);
        end
        frames(1);
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit} !== 8'h02) begin
            n_fail++; $display("FAIL hold_single_dec: got %h expected 02", {tif.tens_digit, tif.ones_digit});
        end
    endtask

    task automatic test_start_in_hold();
        tif.hold = 1'b1;
        tick(1);
        tif.start = 1'b1;
        tick(1);
        tif.start = 1'b0;
        tif.hold  = 1'b0;
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit, tif.running} !== {8'h03, 1'b1}) begin
            n_fail++; $display("FAIL start_in_hold: got %h run %b expected 03 run 1", {tif.tens_digit, tif.ones_digit}, tif.running);
        end
        frames(1);
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit} !== 8'h03) begin
            n_fail++; $display("FAIL frame_cnt_restart: got %h expected 03", {tif.tens_digit, tif.ones_digit});
        end
        frames(1);
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit} !== 8'h02) begin
            n_fail++; $display("FAIL after_restart_dec: got %h expected 02", {tif.tens_digit, tif.ones_digit});
        end
    endtask

    task automatic test_idle_priority_and_reset();
        do_reset();
        tif.start = 1'b1;
        tif.hold  = 1'b1;
        tick(1);
        tif.start = 1'b0;
        tif.hold  = 1'b0;
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit, tif.running} !== {8'h03, 1'b1}) begin
            n_fail++; $display("FAIL start_beats_hold: got %h run %b expected 03 run 1", {tif.tens_digit, tif.ones_digit}, tif.running);
        end
        frames(2);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit, tif.running, tif.expired, tif.warn} !== {8'h03, 3'b000}) begin
            n_fail++; $display("FAIL reset_mid_round: got %h %b%b%b expected 03 000", {tif.tens_digit, tif.ones_digit}, tif.running, tif.expired, tif.warn);
        end
    endtask

    task automatic test_bonus();
        int t;
        pulse_start();
        tif.add_bonus = 1'b1;
        tick(1);
        tif.add_bonus = 1'b0;
`ifdef BONUS_TIME_EN
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit} !== 8'h08) begin
            n_fail++; $display("FAIL bonus_03_to_08: got %h expected 08", {tif.tens_digit, tif.ones_digit});
        end
        for (int i = 0; i < 18; i++) begin
            tif.add_bonus = 1'b1;
            tick(1);
            tif.add_bonus = 1'b0;
        end
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit} !== 8'h98) begin
            n_fail++; $display("FAIL bonus_to_98: got %h expected 98", {tif.tens_digit, tif.ones_digit});
        end
        frames(2);
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit} !== 8'h97) begin
            n_fail++; $display("FAIL dec_to_97: got %h expected 97", {tif.tens_digit, tif.ones_digit});
        end
        tif.add_bonus = 1'b1;
        tick(1);
        tif.add_bonus = 1'b0;
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit} !== 8'h99) begin
            n_fail++; $display("FAIL bonus_saturate: got %h expected 99", {tif.tens_digit, tif.ones_digit});
        end
        pulse_start();
        frames(1);
        frame_pulse(1'b1, t);
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit, tif.running} !== {8'h07, 1'b1}) begin
            n_fail++; $display("FAIL bonus_with_tick: got %h run %b expected 07 run 1", {tif.tens_digit, tif.ones_digit}, tif.running);
        end
`else
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit} !== 8'h03) begin
            n_fail++; $display("FAIL bonus_ignored: got %h expected 03", {tif.tens_digit, tif.ones_digit});
        end
        frames(1);
        frame_pulse(1'b1, t);
        n_checks++;
        if ({tif.tens_digit, tif.ones_digit} !== 8'h02) begin
            n_fail++; $display("FAIL bonus_ignored_tick: got %h expected 02", {tif.tens_digit, tif.ones_digit});
        end
`endif
    endtask

    initial begin
        Reset         = 1'b1;
        tif.frame_clk = 1'b0;
        tif.start     = 1'b0;
        tif.hold      = 1'b0;
        tif.add_bonus = 1'b0;
        test_reset();
        test_countdown();
        test_hold();
        test_start_in_hold();
        test_idle_priority_and_reset();
        test_bonus();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
